// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_pkg;

   // Fetch controller states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      FAULT = 3'd4
   } state_t;

   // Fault cause encodings reported on fault_cause_o.
   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_BUSERR   = 2'b10;
   localparam logic [1:0] FC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/if_timeout_ctr.sv
// Response-wait counter: counts cycles spent waiting for rvalid and flags
// when the configured limit is reached.
module if_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr,
   input  logic en,
   output logic hit
);

   logic [7:0] count;

   // Count register: clear wins over enable, otherwise hold.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count <= 8'd0;
      end else if (clr) begin
         count <= 8'd0;
      end else if (en) begin
         count <= count + 8'd1;
      end else begin
         count <= count;
      end
   end

   assign hit = (count == 8'(TIMEOUT_CYCLES));

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: fetches the word at pc_i over a req/gnt/rvalid
// bus, presents it to decode via valid/ready, drives the PC write enable and
// reports misaligned, bus-error and timeout faults.
module if_fetch_ctrl
   import if_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            redirect_i,
   output logic            pc_en_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            imem_err_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            fault_o,
   output logic [1:0]      fault_cause_o
);

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] pc_q;
   logic [1:0]      cause_q;
   logic [1:0]      cause_nxt;
   logic            discard_q;
   logic            discard_nxt;
   logic            latch_pc;
   logic            load_instr;
   logic            ctr_clr;
   logic            ctr_en;
   logic            ctr_hit;
   logic            aligned;

   if_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_ctr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (ctr_clr),
      .en    (ctr_en),
      .hit   (ctr_hit)
   );

   assign aligned       = (pc_i[1:0] == 2'b00);
   assign imem_req_o    = (state == REQ) && aligned;
   assign imem_addr_o   = (state == REQ) ? pc_i : {XLEN{1'b0}};
   assign instr_valid_o = (state == HOLD);
   assign fault_o       = (state == FAULT);
   assign fault_cause_o = cause_q;
   assign pc_en_o       = (instr_valid_o && instr_ready_i) || redirect_i;

   // Next-state, fault cause, discard flag and datapath load strobes.
   always_comb begin
      state_nxt   = state;
      cause_nxt   = cause_q;
      discard_nxt = discard_q;
      latch_pc    = 1'b0;
      load_instr  = 1'b0;
      ctr_clr     = 1'b0;
      ctr_en      = 1'b0;
      case (state)
         IDLE: begin
            if (redirect_i) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (!aligned) begin
               // A redirect replaces the bad PC, so it is not a fault.
               if (redirect_i) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = FAULT;
                  cause_nxt = FC_MISALIGN;
               end
            end else if (imem_gnt_i) begin
               state_nxt   = WAIT;
               latch_pc    = 1'b1;
               ctr_clr     = 1'b1;
               discard_nxt = redirect_i;
            end else if (redirect_i) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = REQ;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               if (discard_q || redirect_i) begin
                  state_nxt   = IDLE;
                  discard_nxt = 1'b0;
               end else if (imem_err_i) begin
                  state_nxt = FAULT;
                  cause_nxt = FC_BUSERR;
               end else begin
                  state_nxt  = HOLD;
                  load_instr = 1'b1;
               end
            end else begin
               ctr_en = 1'b1;
               if (ctr_hit) begin
                  state_nxt   = FAULT;
                  cause_nxt   = FC_TIMEOUT;
                  discard_nxt = 1'b0;
               end else if (redirect_i) begin
                  state_nxt   = WAIT;
                  discard_nxt = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         HOLD: begin
            if (redirect_i) begin
               state_nxt = IDLE;
            end else if (instr_ready_i) begin
               state_nxt = REQ;
            end else begin
               state_nxt = HOLD;
            end
         end
         FAULT: begin
            if (redirect_i) begin
               state_nxt = IDLE;
               cause_nxt = FC_NONE;
            end else begin
               state_nxt = FAULT;
            end
         end
         default: begin
            state_nxt   = IDLE;
            cause_nxt   = FC_NONE;
            discard_nxt = 1'b0;
         end
      endcase
   end

   // State, cause and discard registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cause_q   <= FC_NONE;
         discard_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cause_q   <= cause_nxt;
         discard_q <= discard_nxt;
      end
   end

   // Fetch PC capture at grant and instruction/PC capture on a good response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q       <= {XLEN{1'b0}};
         instr_o    <= {XLEN{1'b0}};
         instr_pc_o <= {XLEN{1'b0}};
      end else begin
         if (latch_pc) begin
            pc_q <= pc_i;
         end
         if (load_instr) begin
            instr_o    <= imem_rdata_i;
            instr_pc_o <= pc_q;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        redirect;
   logic        pc_en;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   logic        ivalid;
   logic        iready;
   logic [31:0] instr;
   logic [31:0] ipc;
   logic        fault;
   logic [1:0]  cause;

   int checks = 0;
   int errors = 0;

   if_fetch_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(15)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pc_i          (pc),
      .redirect_i    (redirect),
      .pc_en_o       (pc_en),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .imem_err_i    (err),
      .instr_valid_o (ivalid),
      .instr_ready_i (iready),
      .instr_o       (instr),
      .instr_pc_o    (ipc),
      .fault_o       (fault),
      .fault_cause_o (cause)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; pc = 32'h0; redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      rdata = 32'h0; err = 1'b0; iready = 1'b0;
      repeat (2) tick();
      check("rst_valid", 32'(ivalid), 32'd0);
      check("rst_req",   32'(req),    32'd0);
      check("rst_fault", 32'(fault),  32'd0);
      check("rst_instr", instr,       32'h0);
      check("rst_cause", 32'(cause),  32'd0);

      // T1: IDLE -> REQ (gnt) -> WAIT (rvalid) -> HOLD
      rst = 1'b0; settle();
      check("t1_idle_req", 32'(req), 32'd0);
      tick(); gnt = 1'b1; settle();
      check("t1_req", 32'(req), 32'd1);
      check("t1_addr", addr, 32'h0);
      tick(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00500093; settle();
      check("t1_wait_valid", 32'(ivalid), 32'd0);
      check("t1_wait_req", 32'(req), 32'd0);
      tick(); rvalid = 1'b0; rdata = 32'h0; settle();
      check("t1_valid", 32'(ivalid), 32'd1);
      check("t1_instr", instr, 32'h00500093);
      check("t1_ipc", ipc, 32'h0);
      check("t1_pcen_noready", 32'(pc_en), 32'd0);
      iready = 1'b1; settle();
      check("t1_pcen", 32'(pc_en), 32'd1);
      tick(); iready = 1'b0; pc = 32'h4; settle();
      check("t1_pcen_off", 32'(pc_en), 32'd0);
      check("t1_valid_off", 32'(ivalid), 32'd0);

      // T2: grant delayed 3 cycles, response delayed 4 cycles
      for (int i = 0; i < 3; i++) begin
         check("t2_req_hold", 32'(req), 32'd1);
         check("t2_addr_hold", addr, 32'h4);
         tick();
      end
      gnt = 1'b1; settle();
      check("t2_req_gnt", 32'(req), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         settle();
         check("t2_wait_noreq", 32'(req), 32'd0);
         check("t2_wait_nofault", 32'(fault), 32'd0);
         tick();
      end
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00a00113; settle();
      tick(); rvalid = 1'b0; settle();
      check("t2_valid", 32'(ivalid), 32'd1);
      check("t2_instr", instr, 32'h00a00113);
      check("t2_ipc", ipc, 32'h4);
      check("t2_nofault", 32'(fault), 32'd0);
      iready = 1'b1;
      tick(); iready = 1'b0;

      // T3: misaligned PC faults, redirect recovers and fetches from 0x8
      pc = 32'h6; settle();
      check("t3_noreq", 32'(req), 32'd0);
      tick();
      check("t3_fault", 32'(fault), 32'd1);
      check("t3_cause", 32'(cause), 32'd1);
      tick();
      check("t3_sticky", 32'(fault), 32'd1);
      check("t3_fault_noreq", 32'(req), 32'd0);
      redirect = 1'b1; settle();
      check("t3_redir_pcen", 32'(pc_en), 32'd1);
      tick(); redirect = 1'b0; pc = 32'h8; settle();
      check("t3_fault_clr", 32'(fault), 32'd0);
      check("t3_cause_clr", 32'(cause), 32'd0);
      tick();
      check("t3_req8", 32'(req), 32'd1);
      check("t3_addr8", addr, 32'h8);
      gnt = 1'b1;
      tick(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h11111111;
      tick(); rvalid = 1'b0;
      check("t3_ipc", ipc, 32'h8);
      check("t3_instr", instr, 32'h11111111);
      iready = 1'b1;
      tick(); iready = 1'b0; pc = 32'hC;

      // T4: redirect while waiting drops the response
      gnt = 1'b1;
      tick(); gnt = 1'b0; redirect = 1'b1; settle();
      check("t4_pcen", 32'(pc_en), 32'd1);
      tick(); redirect = 1'b0; pc = 32'h100; rvalid = 1'b1; rdata = 32'hDEADBEEF; settle();
      check("t4_still_wait", 32'(req), 32'd0);
      tick(); rvalid = 1'b0; settle();
      check("t4_dropped", 32'(ivalid), 32'd0);
      tick();
      check("t4_dropped2", 32'(ivalid), 32'd0);
      check("t4_req", 32'(req), 32'd1);
      check("t4_addr", addr, 32'h100);

      // T5a: response timeout
      gnt = 1'b1;
      tick(); gnt = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("t5_pre_timeout", 32'(fault), 32'd0);
      tick();
      check("t5_timeout", 32'(fault), 32'd1);
      check("t5_cause_to", 32'(cause), 32'd3);
      redirect = 1'b1;
      tick(); redirect = 1'b0; pc = 32'h200;
      tick();
      check("t5_req", 32'(req), 32'd1);

      // T5b: bus error response
      gnt = 1'b1;
      tick(); gnt = 1'b0; rvalid = 1'b1; err = 1'b1;
      tick(); rvalid = 1'b0; err = 1'b0;
      check("t5_buserr", 32'(fault), 32'd1);
      check("t5_cause_be", 32'(cause), 32'd2);
      check("t5_be_novalid", 32'(ivalid), 32'd0);
      redirect = 1'b1;
      tick(); redirect = 1'b0;
      tick();

      // T5c: response on the timeout-hit cycle wins
      gnt = 1'b1;
      tick(); gnt = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      rvalid = 1'b1; rdata = 32'h12345678;
      tick(); rvalid = 1'b0;
      check("t5_race_valid", 32'(ivalid), 32'd1);
      check("t5_race_nofault", 32'(fault), 32'd0);
      check("t5_race_instr", instr, 32'h12345678);
      check("t5_race_ipc", ipc, 32'h200);

      // T6: HOLD stability, redirect+ready, reset mid-WAIT
      for (int i = 0; i < 5; i++) begin
         rdata = 32'hA0000000 + 32'(i); rvalid = i[0];
         tick();
         check("t6_stable", instr, 32'h12345678);
         check("t6_valid", 32'(ivalid), 32'd1);
      end
      rvalid = 1'b0; redirect = 1'b1; iready = 1'b1; settle();
      check("t6_pcen_pulse", 32'(pc_en), 32'd1);
      tick(); redirect = 1'b0; iready = 1'b0; settle();
      check("t6_idle_valid", 32'(ivalid), 32'd0);
      check("t6_idle_pcen", 32'(pc_en), 32'd0);
      check("t6_idle_req", 32'(req), 32'd0);
      tick(); pc = 32'h300; settle();
      check("t6_req", 32'(req), 32'd1);
      gnt = 1'b1;
      tick(); gnt = 1'b0;
      tick();
      rst = 1'b1; settle();
      check("t6_rst_instr", instr, 32'h0);
      check("t6_rst_ipc", ipc, 32'h0);
      check("t6_rst_valid", 32'(ivalid), 32'd0);
      check("t6_rst_req", 32'(req), 32'd0);
      check("t6_rst_addr", addr, 32'h0);
      check("t6_rst_fault", 32'(fault), 32'd0);
      check("t6_rst_cause", 32'(cause), 32'd0);
      check("t6_rst_pcen", 32'(pc_en), 32'd0);
      tick();
      rst = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D;
      tick(); rvalid = 1'b0;
      check("t6_post_rst_novalid", 32'(ivalid), 32'd0);
      tick();
      check("t6_post_rst_novalid2", 32'(ivalid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
